// File: rtl/rosc_beat_counter_if.sv
// Signal bundle between the ring-oscillator measurement block and its controller.
// The controller drives the request and the oscillator lines; the block returns status and results.
interface rosc_beat_counter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] window;
  logic             ref_osc;
  logic             str_osc;
  logic             osc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ref_cnt;
  logic [CNT_W-1:0] str_cnt;
  logic [CNT_W:0]   delta;
  logic             ovf;

  modport master (
    output start, window, ref_osc, str_osc,
    input  osc_en, busy, done, ref_cnt, str_cnt, delta, ovf
  );

  modport slave (
    input  start, window, ref_osc, str_osc,
    output osc_en, busy, done, ref_cnt, str_cnt, delta, ovf
  );
endinterface

// File: rtl/rosc_beat_counter.sv
// Aging odometer readout: counts stressed and reference ring-oscillator edges over a
// programmable CLK window and reports both counts plus their signed difference.
module rosc_beat_counter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rosc_beat_counter_if.slave  io_bus
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int DRN_W = $clog2(SYNC_STAGES + 2);
  localparam int TMR_A = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam int TMR_W = (TMR_A > DRN_W) ? TMR_A : DRN_W;

  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt;
  logic [TMR_W-1:0]       r_tmr;
  logic [TMR_W-1:0]       w_tmr_load;
  logic                   w_tmr_zero;
  logic [WIN_W-1:0]       r_win;

  logic [SYNC_STAGES-1:0] r_ref_sync;
  logic [SYNC_STAGES-1:0] r_str_sync;
  logic                   r_ref_hist;
  logic                   r_str_hist;
  logic                   w_ref_edge;
  logic                   w_str_edge;

  logic [CNT_W-1:0]       r_ref_cnt;
  logic [CNT_W-1:0]       r_str_cnt;
  logic [CNT_W:0]         r_delta;
  logic                   r_ovf;
  logic                   r_osc_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_clr;
  logic                   w_count_en;

  assign w_tmr_zero = (r_tmr == TMR_ZERO);
  assign w_ref_edge = r_ref_sync[SYNC_STAGES-1] & ~r_ref_hist;
  assign w_str_edge = r_str_sync[SYNC_STAGES-1] & ~r_str_hist;
  assign w_clr      = (r_state == ST_SETTLE) && (w_nxt != ST_SETTLE);
  assign w_count_en = (r_state == ST_COUNT);

  // Oscillator synchronizers and the history flop used for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_sync <= {SYNC_STAGES{1'b0}};
      r_str_sync <= {SYNC_STAGES{1'b0}};
      r_ref_hist <= 1'b0;
      r_str_hist <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[SYNC_STAGES-2:0], io_bus.ref_osc};
      r_str_sync <= {r_str_sync[SYNC_STAGES-2:0], io_bus.str_osc};
      r_ref_hist <= r_ref_sync[SYNC_STAGES-1];
      r_str_hist <= r_str_sync[SYNC_STAGES-1];
    end
  end

  // Next-state selection; every phase length is timed by r_tmr counting down to zero
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) w_nxt = ST_SETTLE;
        else              w_nxt = ST_IDLE;
      end
      ST_SETTLE: begin
        if (!w_tmr_zero)          w_nxt = ST_SETTLE;
        else if (r_win == WIN_ZERO) w_nxt = ST_DRAIN;
        else                      w_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_tmr_zero) w_nxt = ST_DRAIN;
        else            w_nxt = ST_COUNT;
      end
      ST_DRAIN: begin
        if (w_tmr_zero) w_nxt = ST_REPORT;
        else            w_nxt = ST_DRAIN;
      end
      ST_REPORT: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Phase length loaded on entry: timer holds (cycles - 1) for the phase being entered
  always_comb begin
    w_tmr_load = TMR_ZERO;
    case (w_nxt)
      ST_SETTLE: w_tmr_load = TMR_W'(SETTLE_CYC - 1);
      ST_COUNT:  w_tmr_load = TMR_W'(r_win) - TMR_ONE;
      ST_DRAIN:  w_tmr_load = TMR_W'(SYNC_STAGES);
      default:   w_tmr_load = TMR_ZERO;
    endcase
  end

  // State, phase timer and captured window length
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= TMR_ZERO;
      r_win   <= WIN_ZERO;
    end else begin
      r_state <= w_nxt;
      if (r_state != w_nxt)  r_tmr <= w_tmr_load;
      else if (!w_tmr_zero)  r_tmr <= r_tmr - TMR_ONE;
      else                   r_tmr <= r_tmr;
      if ((r_state == ST_IDLE) && io_bus.start) r_win <= io_bus.window;
      else                                      r_win <= r_win;
    end
  end

  // Edge counters saturate at all-ones; previous results survive until SETTLE exits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_cnt <= CNT_ZERO;
      r_str_cnt <= CNT_ZERO;
      r_delta   <= {(CNT_W+1){1'b0}};
      r_ovf     <= 1'b0;
    end else if (w_clr) begin
      r_ref_cnt <= CNT_ZERO;
      r_str_cnt <= CNT_ZERO;
      r_delta   <= {(CNT_W+1){1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      if (w_count_en && w_ref_edge) begin
        if (&r_ref_cnt) r_ovf     <= 1'b1;
        else            r_ref_cnt <= r_ref_cnt + CNT_ONE;
      end
      if (w_count_en && w_str_edge) begin
        if (&r_str_cnt) r_ovf     <= 1'b1;
        else            r_str_cnt <= r_str_cnt + CNT_ONE;
      end
      if ((r_state == ST_DRAIN) && (w_nxt == ST_REPORT))
        r_delta <= {1'b0, r_str_cnt} - {1'b0, r_ref_cnt};
    end
  end

  // Status outputs registered from the upcoming state so they line up with it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_osc_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_osc_en <= (w_nxt == ST_SETTLE) || (w_nxt == ST_COUNT);
      r_busy   <= (w_nxt != ST_IDLE);
      r_done   <= (w_nxt == ST_REPORT);
    end
  end

  assign io_bus.osc_en  = r_osc_en;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.ref_cnt = r_ref_cnt;
  assign io_bus.str_cnt = r_str_cnt;
  assign io_bus.delta   = r_delta;
  assign io_bus.ovf     = r_ovf;

endmodule

// File: tb/tb_rosc_beat_counter.sv
// Randomized bench: two instances (16-bit and 8-bit counters) share stimulus and are
// checked against edge counts predicted from oscillator period and window length.
module tb_rosc_beat_counter;
  localparam int WIN_W       = 16;
  localparam int SETTLE_CYC  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CW_A        = 16;
  localparam int CW_B        = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIN_W-1:0] window = '0;
  logic             ref_osc = 1'b0;
  logic             str_osc = 1'b0;
  int               ref_per = 8;
  int               str_per = 8;
  int               checks = 0;
  int               errors = 0;
  int               done_a = 0;
  int               done_b = 0;

  rosc_beat_counter_if #(.CNT_W(CW_A), .WIN_W(WIN_W)) bus_a ();
  rosc_beat_counter_if #(.CNT_W(CW_B), .WIN_W(WIN_W)) bus_b ();

  assign bus_a.start   = start;
  assign bus_a.window  = window;
  assign bus_a.ref_osc = ref_osc;
  assign bus_a.str_osc = str_osc;
  assign bus_b.start   = start;
  assign bus_b.window  = window;
  assign bus_b.ref_osc = ref_osc;
  assign bus_b.str_osc = str_osc;

  rosc_beat_counter #(.CNT_W(CW_A), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC),
                      .SYNC_STAGES(SYNC_STAGES)) dut_a (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_a.slave));

  rosc_beat_counter #(.CNT_W(CW_B), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC),
                      .SYNC_STAGES(SYNC_STAGES)) dut_b (
    .i_clk(clk), .i_rst(rst), .io_bus(bus_b.slave));

  always #5 clk = ~clk;

  // Free-running oscillators, phase-offset so their edges never coincide with CLK edges
  initial begin
    #3;
    forever begin
      #(ref_per * 5);
      ref_osc = ~ref_osc;
    end
  end

  initial begin
    #3;
    forever begin
      #(str_per * 5);
      str_osc = ~str_osc;
    end
  end

  always @(negedge clk) begin
    if (bus_a.done) done_a++;
    if (bus_b.done) done_b++;
  end

  task automatic chk(input string tag, input longint obs, input longint lo, input longint hi);
    checks++;
    if (obs < lo || obs > hi) begin
      errors++;
      $display("FAIL %s got %0d want [%0d..%0d]", tag, obs, lo, hi);
    end
  endtask

  // A W-cycle window over a period-P oscillator holds floor or ceil of W/P edges;
  // ovf_st: 0 surely clear, 1 surely set, 2 too close to call
  task automatic model_cnt(input int w, input int per, input int maxv,
                           output int lo, output int hi, output int ovf_st);
    int raw_lo, raw_hi;
    if (w == 0) begin
      raw_lo = 0;
      raw_hi = 0;
    end else begin
      raw_lo = (w / per) - 1;
      if (raw_lo < 0) raw_lo = 0;
      raw_hi = (w / per) + 1;
    end
    lo = (raw_lo > maxv) ? maxv : raw_lo;
    hi = (raw_hi > maxv) ? maxv : raw_hi;
    if (raw_lo > maxv)       ovf_st = 1;
    else if (raw_hi <= maxv) ovf_st = 0;
    else                     ovf_st = 2;
  endtask

  task automatic chk_results(input string nm, input int w, input int pr, input int ps,
                             input int maxv, input longint rc, input longint sc,
                             input longint dl, input longint ov);
    int rlo, rhi, rov, slo, shi, sov;
    model_cnt(w, pr, maxv, rlo, rhi, rov);
    model_cnt(w, ps, maxv, slo, shi, sov);
    chk({nm, "_ref_cnt"}, rc, rlo, rhi);
    chk({nm, "_str_cnt"}, sc, slo, shi);
    chk({nm, "_delta"}, dl, slo - rhi, shi - rlo);
    if (rov == 1 || sov == 1)      chk({nm, "_ovf"}, ov, 1, 1);
    else if (rov == 0 && sov == 0) chk({nm, "_ovf"}, ov, 0, 0);
  endtask

  task automatic run_meas(input int w, input int pr, input int ps, input bit noise);
    int da, db, n, budget, exp_lat;
    bit got;
    ref_per = pr;
    str_per = ps;
    repeat (25) @(negedge clk);
    da = done_a;
    db = done_b;
    exp_lat = 1 + SETTLE_CYC + w + SYNC_STAGES + 1 + 1;
    budget = exp_lat + 20;
    start = 1'b1;
    window = WIN_W'(w);
    @(negedge clk);
    start = 1'b0;
    window = WIN_W'($urandom);
    n = 0;
    got = 1'b0;
    while (n < budget) begin
      if (bus_a.done) begin
        got = 1'b1;
        break;
      end
      start = (noise && ($urandom_range(0, 15) == 0)) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", longint'(got), 1, 1);
    chk("latency", n + 2, exp_lat, exp_lat);
    chk("done_b", bus_b.done, 1, 1);
    chk("busy_in_report", bus_a.busy, 1, 1);
    chk("osc_en_in_report", bus_a.osc_en, 0, 0);
    chk_results("a", w, pr, ps, (1 << CW_A) - 1, bus_a.ref_cnt, bus_a.str_cnt,
                longint'($signed(bus_a.delta)), bus_a.ovf);
    chk_results("b", w, pr, ps, (1 << CW_B) - 1, bus_b.ref_cnt, bus_b.str_cnt,
                longint'($signed(bus_b.delta)), bus_b.ovf);
    @(negedge clk);
    chk("busy_after", bus_a.busy, 0, 0);
    chk("done_after", bus_a.done, 0, 0);
    repeat (30) @(negedge clk);
    chk("one_done_a", done_a - da, 1, 1);
    chk("one_done_b", done_b - db, 1, 1);
  endtask

  initial begin
    int da;
    repeat (3) @(negedge clk);
    chk("rst_osc_en", bus_a.osc_en, 0, 0);
    chk("rst_busy", bus_a.busy, 0, 0);
    chk("rst_done", bus_a.done, 0, 0);
    chk("rst_ref_cnt", bus_a.ref_cnt, 0, 0);
    chk("rst_str_cnt", bus_a.str_cnt, 0, 0);
    chk("rst_delta", bus_a.delta, 0, 0);
    chk("rst_ovf", bus_a.ovf, 0, 0);
    rst = 1'b0;

    run_meas(800, 8, 8, 1'b1);
    run_meas(4000, 8, 10, 1'b1);
    run_meas(2000, 4, 12, 1'b0);
    run_meas(0, 4, 5, 1'b1);
    for (int k = 0; k < 5; k++)
      run_meas($urandom_range(1, 700), $urandom_range(4, 20), $urandom_range(4, 20), 1'b1);

    // Abort mid-COUNT with both oscillators running
    ref_per = 5;
    str_per = 7;
    repeat (25) @(negedge clk);
    da = done_a;
    start = 1'b1;
    window = WIN_W'(400);
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("pre_abort_osc_en", bus_a.osc_en, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_osc_en_a", bus_a.osc_en, 0, 0);
    chk("abort_osc_en_b", bus_b.osc_en, 0, 0);
    chk("abort_busy", bus_a.busy, 0, 0);
    chk("abort_ref_cnt", bus_a.ref_cnt, 0, 0);
    chk("abort_str_cnt", bus_a.str_cnt, 0, 0);
    chk("abort_delta", bus_a.delta, 0, 0);
    chk("abort_ovf", bus_a.ovf, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    chk("abort_no_done", done_a - da, 0, 0);

    run_meas(300, 6, 9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
